// File: rtl/arbiter_pkg.sv
// Purpose : shared types and helpers for the bus arbiter slice.
// Latency : n/a (types, constants and a pure function only).
// Backpr. : n/a.
// Contents: arb_mode_e (arbitration policy), arb_state_e (arbiter FSM states),
//           HOLD_CNT_W (tenure counter width, covers MAX_HOLD up to 255),
//           wrap_inc() (modulo-N increment used for the rotation pointer).
package arbiter_pkg;

   typedef enum logic {
      ARB_FIXED = 1'b0,
      ARB_RR    = 1'b1
   } arb_mode_e;

   typedef enum logic {
      IDLE  = 1'b0,
      OWNED = 1'b1
   } arb_state_e;

   localparam int HOLD_CNT_W = 8;

   function automatic int wrap_inc(input int idx, input int n);
      return (idx + 1 >= n) ? 0 : idx + 1;
   endfunction

endpackage

// File: rtl/arb_rotate_pick.sv
// Purpose : pick the first eligible requester at or above a start pointer, wrapping.
// Latency : purely combinational.
// Backpr. : none; the caller decides when to use the result.
// Ports   : req  - request vector, bit i = master i
//           ptr  - index where the search starts
//           mask - masters excluded from this pick
//           vld  - some eligible requester exists
//           idx  - index of the chosen requester (0 when vld is low)
module arb_rotate_pick #(
   parameter  int NUM_MASTERS = 4,
   localparam int IDX_W       = $clog2(NUM_MASTERS)
) (
   input  logic [NUM_MASTERS-1:0] req,
   input  logic [IDX_W-1:0]       ptr,
   input  logic [NUM_MASTERS-1:0] mask,
   output logic                   vld,
   output logic [IDX_W-1:0]       idx
);

   logic [NUM_MASTERS-1:0] eligible;
   int                     cand;

   always_comb begin
      eligible = req & ~mask;
      vld      = 1'b0;
      idx      = '0;
      cand     = 0;
      // Walk ptr, ptr+1, ... wrapping at NUM_MASTERS; first hit wins.
      for (int k = 0; k < NUM_MASTERS; k++) begin
         cand = int'(ptr) + k;
         if (cand >= NUM_MASTERS) begin
            cand = cand - NUM_MASTERS;
         end
         if (!vld && eligible[cand[IDX_W-1:0]]) begin
            vld = 1'b1;
            idx = cand[IDX_W-1:0];
         end
      end
   end

endmodule

// File: rtl/bus_arbiter_rr.sv
// Purpose : N-master bus arbiter, fixed-priority or round-robin, with bus turnaround.
// Latency : request-to-grant one cycle; at least one all-zero grant cycle between owners.
// Backpr. : owner keeps the bus while its request stays high; others wait, nothing is lost.
// Ports   : clk, rstn (async active-low), BREQ (request levels), BGRANT (registered
//           one-hot-or-zero grant), OWNER_ID (granted index, 0 when idle),
//           BUS_BUSY (any grant), TIMEOUT (one-cycle pulse on forced revocation).
// Macro   : ARB_TIMEOUT_EN compiles in the MAX_HOLD tenure limit; without it TIMEOUT is 0.
module bus_arbiter_rr
   import arbiter_pkg::*;
#(
   parameter  int        NUM_MASTERS = 4,
   parameter  arb_mode_e ARB_MODE    = ARB_RR,
   parameter  int        MAX_HOLD    = 16,
   localparam int        IDX_W       = $clog2(NUM_MASTERS)
) (
   input  logic                   clk,
   input  logic                   rstn,
   input  logic [NUM_MASTERS-1:0] BREQ,
   output logic [NUM_MASTERS-1:0] BGRANT,
   output logic [IDX_W-1:0]       OWNER_ID,
   output logic                   BUS_BUSY,
   output logic                   TIMEOUT
);

   arb_state_e             state;
   arb_state_e             state_nxt;
   logic [NUM_MASTERS-1:0] grant_nxt;
   logic [IDX_W-1:0]       owner_nxt;
   logic [IDX_W-1:0]       ptr;
   logic [IDX_W-1:0]       ptr_nxt;
   logic [IDX_W-1:0]       pick_ptr;
   logic [IDX_W-1:0]       pick_idx;
   logic [NUM_MASTERS-1:0] pick_mask;
   logic                   pick_vld;
   logic                   owner_req;

   // Fixed priority is just a rotating search that always starts at master 0.
   assign pick_ptr  = (ARB_MODE == ARB_FIXED) ? '0 : ptr;
   assign owner_req = BREQ[OWNER_ID];
   assign BUS_BUSY  = |BGRANT;

`ifdef ARB_TIMEOUT_EN
   localparam logic [HOLD_CNT_W-1:0] MAX_HOLD_C = HOLD_CNT_W'(MAX_HOLD);

   logic [HOLD_CNT_W-1:0]  hold_cnt;
   logic [HOLD_CNT_W-1:0]  hold_cnt_nxt;
   logic [NUM_MASTERS-1:0] excl;
   logic [NUM_MASTERS-1:0] excl_nxt;
   logic                   tmo_nxt;
   logic                   others_req;

   assign others_req = |(BREQ & ~BGRANT);
   assign pick_mask  = excl;
`else
   assign pick_mask  = '0;
   assign TIMEOUT    = 1'b0;
`endif

   arb_rotate_pick #(
      .NUM_MASTERS (NUM_MASTERS)
   ) u_pick (
      .req  (BREQ),
      .ptr  (pick_ptr),
      .mask (pick_mask),
      .vld  (pick_vld),
      .idx  (pick_idx)
   );

   always_comb begin
      state_nxt = state;
      grant_nxt = BGRANT;
      owner_nxt = OWNER_ID;
      ptr_nxt   = ptr;
`ifdef ARB_TIMEOUT_EN
      hold_cnt_nxt = hold_cnt;
      excl_nxt     = excl;
      tmo_nxt      = 1'b0;
`endif
      case (state)
         IDLE: begin
`ifdef ARB_TIMEOUT_EN
            // A revoked master sits out exactly one arbitration.
            excl_nxt = '0;
`endif
            if (pick_vld) begin
               state_nxt = OWNED;
               grant_nxt = NUM_MASTERS'(1) << pick_idx;
               owner_nxt = pick_idx;
               ptr_nxt   = IDX_W'(wrap_inc(int'(pick_idx), NUM_MASTERS));
`ifdef ARB_TIMEOUT_EN
               hold_cnt_nxt = HOLD_CNT_W'(1);
`endif
            end
         end
         OWNED: begin
            // Going through IDLE on every hand-over gives the turnaround cycle.
            if (!owner_req) begin
               state_nxt = IDLE;
               grant_nxt = '0;
               owner_nxt = '0;
`ifdef ARB_TIMEOUT_EN
               hold_cnt_nxt = '0;
`endif
            end
`ifdef ARB_TIMEOUT_EN
            else if (hold_cnt == MAX_HOLD_C && others_req) begin
               state_nxt    = IDLE;
               grant_nxt    = '0;
               owner_nxt    = '0;
               hold_cnt_nxt = '0;
               excl_nxt     = BGRANT;
               tmo_nxt      = 1'b1;
            end else if (hold_cnt != MAX_HOLD_C) begin
               hold_cnt_nxt = hold_cnt + HOLD_CNT_W'(1);
            end
`endif
         end
      endcase
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state    <= IDLE;
         BGRANT   <= '0;
         OWNER_ID <= '0;
         ptr      <= '0;
      end else begin
         state    <= state_nxt;
         BGRANT   <= grant_nxt;
         OWNER_ID <= owner_nxt;
         ptr      <= ptr_nxt;
      end
   end

`ifdef ARB_TIMEOUT_EN
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         hold_cnt <= '0;
         excl     <= '0;
         TIMEOUT  <= 1'b0;
      end else begin
         hold_cnt <= hold_cnt_nxt;
         excl     <= excl_nxt;
         TIMEOUT  <= tmo_nxt;
      end
   end
`endif

endmodule

// File: tb/tb_bus_arbiter_rr.sv
// Purpose : self-checking bench for bus_arbiter_rr, one round-robin and one fixed instance.
// Latency : n/a.
// Backpr. : n/a.
module tb_bus_arbiter_rr;
   import arbiter_pkg::*;

   logic       clk = 1'b0;
   logic       rstn;
   logic [3:0] breq_rr, breq_fx;
   logic [3:0] gnt_rr, gnt_fx;
   logic [1:0] own_rr, own_fx;
   logic       busy_rr, busy_fx, tmo_rr, tmo_fx;

   int n_chk  = 0;
   int n_pass = 0;

   typedef struct {
      logic [3:0] breq;
      logic [3:0] gnt;
      logic [1:0] own;
      logic       tmo;
   } vec_t;

   vec_t tbl[$];

   always #5 clk = ~clk;

   bus_arbiter_rr #(.NUM_MASTERS(4), .ARB_MODE(ARB_RR), .MAX_HOLD(4)) u_rr (
      .clk      (clk),
      .rstn     (rstn),
      .BREQ     (breq_rr),
      .BGRANT   (gnt_rr),
      .OWNER_ID (own_rr),
      .BUS_BUSY (busy_rr),
      .TIMEOUT  (tmo_rr)
   );

   bus_arbiter_rr #(.NUM_MASTERS(4), .ARB_MODE(ARB_FIXED), .MAX_HOLD(4)) u_fx (
      .clk      (clk),
      .rstn     (rstn),
      .BREQ     (breq_fx),
      .BGRANT   (gnt_fx),
      .OWNER_ID (own_fx),
      .BUS_BUSY (busy_fx),
      .TIMEOUT  (tmo_fx)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
   endtask

   // One rising edge, then sample 1 time unit later; grant must be one-hot-or-zero.
   task automatic step();
      @(posedge clk);
      #1;
      check("onehot0_rr", 32'($onehot0(gnt_rr)), 32'd1);
      check("onehot0_fx", 32'($onehot0(gnt_fx)), 32'd1);
   endtask

   function automatic void add(input logic [3:0] b, input logic [3:0] g,
                               input logic [1:0] o, input logic t);
      vec_t v;
      v.breq = b;
      v.gnt  = g;
      v.own  = o;
      v.tmo  = t;
      tbl.push_back(v);
   endfunction

   task automatic run_table(input string name, input bit fx);
      logic [3:0] g;
      logic [1:0] o;
      logic       b, t;
      foreach (tbl[i]) begin
         if (fx) breq_fx = tbl[i].breq;
         else    breq_rr = tbl[i].breq;
         step();
         g = fx ? gnt_fx  : gnt_rr;
         o = fx ? own_fx  : own_rr;
         b = fx ? busy_fx : busy_rr;
         t = fx ? tmo_fx  : tmo_rr;
         check($sformatf("%s[%0d].grant", name, i), 32'(g), 32'(tbl[i].gnt));
         check($sformatf("%s[%0d].owner", name, i), 32'(o), 32'(tbl[i].own));
         check($sformatf("%s[%0d].busy",  name, i), 32'(b), 32'(|tbl[i].gnt));
         check($sformatf("%s[%0d].tmo",   name, i), 32'(t), 32'(tbl[i].tmo));
      end
      tbl.delete();
   endtask

   task automatic do_reset();
      @(negedge clk);
      rstn    = 1'b0;
      breq_rr = '0;
      breq_fx = '0;
      #1;
      check("rst.grant_rr", 32'(gnt_rr), 32'd0);
      check("rst.owner_rr", 32'(own_rr), 32'd0);
      check("rst.busy_rr",  32'(busy_rr), 32'd0);
      check("rst.tmo_rr",   32'(tmo_rr), 32'd0);
      check("rst.grant_fx", 32'(gnt_fx), 32'd0);
      repeat (2) @(posedge clk);
      @(negedge clk);
      rstn = 1'b1;
   endtask

   initial begin
      logic [3:0] oh;
      int         m;

      rstn    = 1'b0;
      breq_rr = '0;
      breq_fx = '0;
      do_reset();

      // Quiet bus after reset.
      for (int i = 0; i < 20; i++) begin
         step();
         check($sformatf("idle[%0d].rr", i), 32'({gnt_rr, busy_rr, tmo_rr}), 32'd0);
         check($sformatf("idle[%0d].fx", i), 32'({gnt_fx, busy_fx, tmo_fx}), 32'd0);
      end

      // Round-robin basic hand-over with turnaround.
      add(4'b0110, 4'b0010, 2'd1, 1'b0);
      add(4'b0110, 4'b0010, 2'd1, 1'b0);
      add(4'b0100, 4'b0000, 2'd0, 1'b0);
      add(4'b0100, 4'b0100, 2'd2, 1'b0);
      add(4'b0110, 4'b0100, 2'd2, 1'b0);
      add(4'b0000, 4'b0000, 2'd0, 1'b0);
      run_table("rr_basic", 1'b0);

      // Round-robin rotation 0,1,2,3,0, each owning three cycles.
      do_reset();
      for (int k = 0; k < 5; k++) begin
         m  = k % 4;
         oh = 4'b0001 << m;
         add(4'b1111, oh, 2'(m), 1'b0);
         add(4'b1111, oh, 2'(m), 1'b0);
         add(4'b1111, oh, 2'(m), 1'b0);
         add(4'b1111 & ~oh, 4'b0000, 2'd0, 1'b0);
      end
      add(4'b0000, 4'b0000, 2'd0, 1'b0);
      run_table("rr_rotate", 1'b0);

      // Fixed priority: no preemption, then lowest index wins.
      add(4'b1000, 4'b1000, 2'd3, 1'b0);
      add(4'b1111, 4'b1000, 2'd3, 1'b0);
      add(4'b1111, 4'b1000, 2'd3, 1'b0);
      add(4'b1111, 4'b1000, 2'd3, 1'b0);
      add(4'b0111, 4'b0000, 2'd0, 1'b0);
      add(4'b0111, 4'b0001, 2'd0, 1'b0);
      add(4'b0010, 4'b0000, 2'd0, 1'b0);
      add(4'b0011, 4'b0001, 2'd0, 1'b0);
      add(4'b0000, 4'b0000, 2'd0, 1'b0);
      run_table("fx_prio", 1'b1);

      // Tenure limit: master 0 holds while master 2 competes.
      do_reset();
      for (int pass = 0; pass < 2; pass++) begin
         add(4'b0001, 4'b0001, 2'd0, 1'b0);
         add(4'b0101, 4'b0001, 2'd0, 1'b0);
         add(4'b0101, 4'b0001, 2'd0, 1'b0);
         add(4'b0101, 4'b0001, 2'd0, 1'b0);
`ifdef ARB_TIMEOUT_EN
         add(4'b0101, 4'b0000, 2'd0, 1'b1);
         add(4'b0101, 4'b0100, 2'd2, 1'b0);
`else
         add(4'b0101, 4'b0001, 2'd0, 1'b0);
         add(4'b0101, 4'b0001, 2'd0, 1'b0);
         add(4'b0101, 4'b0001, 2'd0, 1'b0);
`endif
         add(4'b0000, 4'b0000, 2'd0, 1'b0);
         run_table(pass == 0 ? "rr_hold" : "fx_hold", pass == 1);
      end

      // Lone owner keeps the bus past MAX_HOLD; a late competitor then wins at once.
      do_reset();
      for (int i = 0; i < 8; i++) add(4'b0001, 4'b0001, 2'd0, 1'b0);
`ifdef ARB_TIMEOUT_EN
      add(4'b0101, 4'b0000, 2'd0, 1'b1);
      add(4'b0101, 4'b0100, 2'd2, 1'b0);
`else
      add(4'b0101, 4'b0001, 2'd0, 1'b0);
      add(4'b0101, 4'b0001, 2'd0, 1'b0);
`endif
      add(4'b0000, 4'b0000, 2'd0, 1'b0);
      run_table("rr_sat", 1'b0);

      // Reset mid-ownership of master 2 drops the grant without a clock edge.
      breq_rr = 4'b0100;
      step();
      check("midrst.pre_grant", 32'(gnt_rr), 32'b0100);
      check("midrst.pre_owner", 32'(own_rr), 32'd2);
      #2;
      rstn    = 1'b0;
      breq_rr = 4'b0101;
      #1;
      check("midrst.grant", 32'(gnt_rr), 32'd0);
      check("midrst.owner", 32'(own_rr), 32'd0);
      check("midrst.busy",  32'(busy_rr), 32'd0);
      repeat (2) @(posedge clk);
      @(negedge clk);
      rstn = 1'b1;
      step();
      check("midrst.post_grant", 32'(gnt_rr), 32'b0001);
      check("midrst.post_owner", 32'(own_rr), 32'd0);
      breq_rr = 4'b0000;
      step();
      check("midrst.release", 32'(gnt_rr), 32'd0);

      // Pointer must return to 0 after reset: own master 1 (pointer 2), reset, ask 0101.
      breq_rr = 4'b0010;
      step();
      check("ptrrst.pre_grant", 32'(gnt_rr), 32'b0010);
      #2;
      rstn    = 1'b0;
      breq_rr = 4'b0101;
      repeat (2) @(posedge clk);
      @(negedge clk);
      rstn = 1'b1;
      step();
      check("ptrrst.post_grant", 32'(gnt_rr), 32'b0001);
      check("ptrrst.post_owner", 32'(own_rr), 32'd0);
      breq_rr = 4'b0000;
      step();

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
